// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter. Each requester owns a one-entry
// holding buffer; one buffer is drained per cycle straight onto the register
// file write port, with round-robin priority applied only under contention.

// One-entry holding buffer for a single requester.
module rfwa_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        offer_valid,
  input  logic [4:0]  offer_dst,
  input  logic [31:0] offer_data,
  input  logic        drain,
  output logic        ready,
  output logic        held_valid,
  output logic [4:0]  held_dst,
  output logic [31:0] held_data
);

  // Drain and refill can coincide on one edge, so full throughput is kept.
  assign ready = !held_valid || drain;

  // Refill wins over drain so a new entry arriving on the draining edge is kept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_valid <= 1'b0;
      held_dst   <= '0;
      held_data  <= '0;
    end else if (offer_valid && ready) begin
      held_valid <= 1'b1;
      held_dst   <= offer_dst;
      held_data  <= offer_data;
    end else if (drain) begin
      held_valid <= 1'b0;
    end
  end

endmodule

module regfile_write_arbiter #(
  parameter bit PRIO_INIT = 1'b0,
  parameter bit DROP_R0   = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqA_Valid,
  input  logic [4:0]  ReqA_Register,
  input  logic [31:0] ReqA_Data,
  output logic        ReqA_Ready,
  input  logic        ReqB_Valid,
  input  logic [4:0]  ReqB_Register,
  input  logic [31:0] ReqB_Data,
  output logic        ReqB_Ready,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic        RegWrite,
  output logic [31:0] Busy,
  output logic        GrantA,
  output logic        GrantB
);

  localparam int NUM_REQ = 2;

  // Index 0 is requester A, index 1 is requester B.
  logic [NUM_REQ-1:0]       offer_valid;
  logic [NUM_REQ-1:0][4:0]  offer_dst;
  logic [NUM_REQ-1:0][31:0] offer_data;
  logic [NUM_REQ-1:0]       ready;
  logic [NUM_REQ-1:0]       held_valid;
  logic [NUM_REQ-1:0][4:0]  held_dst;
  logic [NUM_REQ-1:0][31:0] held_data;
  logic [NUM_REQ-1:0]       grant;
  logic                     prio;      // 0: A wins ties, 1: B wins ties
  logic [31:0]              busy_vec;

  assign offer_valid = {ReqB_Valid, ReqA_Valid};
  assign offer_dst   = {ReqB_Register, ReqA_Register};
  assign offer_data  = {ReqB_Data, ReqA_Data};

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_buf
    rfwa_buf u_buf (
      .clk        (Clk),
      .rst_n      (Reset),
      .offer_valid(offer_valid[i]),
      .offer_dst  (offer_dst[i]),
      .offer_data (offer_data[i]),
      .drain      (grant[i]),
      .ready      (ready[i]),
      .held_valid (held_valid[i]),
      .held_dst   (held_dst[i]),
      .held_data  (held_data[i])
    );
  end

  assign ReqA_Ready = ready[0];
  assign ReqB_Ready = ready[1];

  // Select at most one buffer: a lone valid wins, a tie goes to the pointer.
  always_comb begin
    grant    = '0;
    grant[0] = held_valid[0] && (!held_valid[1] || !prio);
    grant[1] = held_valid[1] && (!held_valid[0] ||  prio);
  end

  assign GrantA = grant[0];
  assign GrantB = grant[1];

  // Drive the write port from the selected buffer; idle port reads as zero.
  always_comb begin
    WriteRegister = '0;
    WriteData     = '0;
    if (grant[0]) begin
      WriteRegister = held_dst[0];
      WriteData     = held_data[0];
    end else if (grant[1]) begin
      WriteRegister = held_dst[1];
      WriteData     = held_data[1];
    end
  end

  // Register 0 writes still drain the buffer but never reach the file.
  assign RegWrite = (|grant) && !(DROP_R0 && (WriteRegister == 5'd0));

  // Pointer flips only after a contended grant, so a loser waits one grant.
  always_ff @(posedge Clk) begin
    if (!Reset)
      prio <= PRIO_INIT;
    else if (&held_valid)
      prio <= ~prio;
  end

  // Scoreboard-style busy vector over every buffered destination.
  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (held_valid[i]) busy_vec[held_dst[i]] = 1'b1;
    if (DROP_R0) busy_vec[0] = 1'b0;
  end

  assign Busy = busy_vec;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench with a scoreboard: stimulus pushes expected grants, a
// monitor pops and compares each time the arbiter grants a buffer.
module tb_regfile_write_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        ReqA_Valid = 1'b0, ReqB_Valid = 1'b0;
  logic [4:0]  ReqA_Register = '0, ReqB_Register = '0;
  logic [31:0] ReqA_Data = '0, ReqB_Data = '0;
  logic        ReqA_Ready, ReqB_Ready;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [31:0] Busy;
  logic        GrantA, GrantB;

  regfile_write_arbiter #(.PRIO_INIT(1'b0), .DROP_R0(1'b1)) dut (
    .Clk(Clk), .Reset(Reset),
    .ReqA_Valid(ReqA_Valid), .ReqA_Register(ReqA_Register), .ReqA_Data(ReqA_Data), .ReqA_Ready(ReqA_Ready),
    .ReqB_Valid(ReqB_Valid), .ReqB_Register(ReqB_Register), .ReqB_Data(ReqB_Data), .ReqB_Ready(ReqB_Ready),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .Busy(Busy), .GrantA(GrantA), .GrantB(GrantB)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        side;   // 0 = A, 1 = B
    logic [4:0]  dst;
    logic [31:0] data;
    logic        we;
  } exp_t;

  exp_t        q[$];
  logic [31:0] rf[32];
  int          total = 0;
  int          passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic side, input logic [4:0] dst,
                              input logic [31:0] data, input logic we);
    exp_t e;
    e.side = side; e.dst = dst; e.data = data; e.we = we;
    return e;
  endfunction

  // Monitor: every grant must match the head of the expected queue.
  always @(negedge Clk) begin
    if (Reset) begin
      if (GrantA || GrantB) begin
        if (q.size() == 0) begin
          chk("unexpected_grant", {30'd0, GrantB, GrantA}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("grant_side", {30'd0, GrantB, GrantA}, e.side ? 32'd2 : 32'd1);
          chk("write_reg",  {27'd0, WriteRegister}, {27'd0, e.dst});
          chk("write_data", WriteData, e.data);
          chk("reg_write",  {31'd0, RegWrite}, {31'd0, e.we});
          if (e.we) chk("busy_bit", {31'd0, Busy[e.dst]}, 32'd1);
          else      chk("busy_r0",  {31'd0, Busy[0]}, 32'd0);
          if (RegWrite) rf[WriteRegister] = WriteData;
        end
      end else if (RegWrite) begin
        chk("we_without_grant", {31'd0, GrantA | GrantB}, 32'd1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Present one offer per side for exactly one edge (buffers assumed empty).
  task automatic send(input logic va, input logic [4:0] ra, input logic [31:0] da,
                      input logic vb, input logic [4:0] rb, input logic [31:0] db);
    ReqA_Valid = va; ReqA_Register = ra; ReqA_Data = da;
    ReqB_Valid = vb; ReqB_Register = rb; ReqB_Data = db;
    tick(1);
    ReqA_Valid = 1'b0; ReqB_Valid = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    tick(1);
    Reset = 1'b1;
  endtask

  task automatic chk_idle(input string tag);
    @(negedge Clk);
    chk({tag, "_regwrite"}, {31'd0, RegWrite}, 32'd0);
    chk({tag, "_wreg"},     {27'd0, WriteRegister}, 32'd0);
    chk({tag, "_wdata"},    WriteData, 32'd0);
    chk({tag, "_busy"},     Busy, 32'd0);
    chk({tag, "_grants"},   {30'd0, GrantB, GrantA}, 32'd0);
    chk({tag, "_ready"},    {30'd0, ReqB_Ready, ReqA_Ready}, 32'd3);
  endtask

  initial begin
    logic acc_a, acc_b;
    int   ai, bi;
    for (int i = 0; i < 32; i++) rf[i] = '0;

    // Reset state
    tick(2);
    chk_idle("reset");
    @(posedge Clk); #1;
    Reset = 1'b1;

    // A alone: reg5 = 10
    q.push_back(mk(1'b0, 5'd5, 32'd10, 1'b1));
    send(1'b1, 5'd5, 32'd10, 1'b0, 5'd0, 32'd0);
    tick(3);
    chk("single_drained", q.size(), 0);

    // Simultaneous accept: A first, B next; B holds priority afterwards
    q.push_back(mk(1'b0, 5'd8, 32'h11, 1'b1));
    q.push_back(mk(1'b1, 5'd9, 32'h22, 1'b1));
    send(1'b1, 5'd8, 32'h11, 1'b1, 5'd9, 32'h22);
    @(negedge Clk);
    chk("pair_readyA", {31'd0, ReqA_Ready}, 32'd1);
    chk("pair_readyB", {31'd0, ReqB_Ready}, 32'd0);
    chk("pair_busy",   Busy, 32'h0000_0300);
    tick(3);
    // B now has priority: a fresh contended pair must go B first
    q.push_back(mk(1'b1, 5'd12, 32'hB2, 1'b1));
    q.push_back(mk(1'b0, 5'd11, 32'hA1, 1'b1));
    send(1'b1, 5'd11, 32'hA1, 1'b1, 5'd12, 32'hB2);
    tick(3);
    chk("pair_drained", q.size(), 0);

    // Continuous contention: A,B,A,B,A,B from PRIO_INIT
    do_reset();
    q.push_back(mk(1'b0, 5'd6, 32'h100, 1'b1));
    q.push_back(mk(1'b1, 5'd7, 32'h200, 1'b1));
    q.push_back(mk(1'b0, 5'd6, 32'h101, 1'b1));
    q.push_back(mk(1'b1, 5'd7, 32'h201, 1'b1));
    q.push_back(mk(1'b0, 5'd6, 32'h102, 1'b1));
    q.push_back(mk(1'b1, 5'd7, 32'h202, 1'b1));
    ReqA_Valid = 1'b1; ReqA_Register = 5'd6; ReqA_Data = 32'h100;
    ReqB_Valid = 1'b1; ReqB_Register = 5'd7; ReqB_Data = 32'h200;
    ai = 0; bi = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      acc_a = ReqA_Valid && ReqA_Ready;
      acc_b = ReqB_Valid && ReqB_Ready;
      if (c >= 1 && c <= 5) begin
        chk("rr_readyA", {31'd0, ReqA_Ready}, (c % 2 == 1) ? 32'd1 : 32'd0);
        chk("rr_readyB", {31'd0, ReqB_Ready}, (c % 2 == 1) ? 32'd0 : 32'd1);
      end
      @(posedge Clk); #1;
      if (acc_a) begin
        ai++;
        if (ai < 3) ReqA_Data = 32'h100 + ai; else ReqA_Valid = 1'b0;
      end
      if (acc_b) begin
        bi++;
        if (bi < 3) ReqB_Data = 32'h200 + bi; else ReqB_Valid = 1'b0;
      end
    end
    tick(2);
    chk("rr_drained", q.size(), 0);

    // Register 0 write is consumed silently
    q.push_back(mk(1'b0, 5'd0, 32'hFF, 1'b0));
    send(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0);
    @(negedge Clk);
    chk("r0_busy_all", Busy, 32'd0);
    tick(2);
    chk("r0_drained", q.size(), 0);

    // Same destination from both sides: later grant persists
    do_reset();
    q.push_back(mk(1'b0, 5'd10, 32'd20, 1'b1));
    q.push_back(mk(1'b1, 5'd10, 32'd30, 1'b1));
    send(1'b1, 5'd10, 32'd20, 1'b1, 5'd10, 32'd30);
    tick(3);
    chk("same_reg_final", rf[10], 32'd30);

    // Reset with both buffers full discards them and reloads the pointer
    tick(1);
    send(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    Reset = 1'b0;
    tick(1);
    chk_idle("midreset");
    Reset = 1'b1;
    q.push_back(mk(1'b0, 5'd1, 32'h1, 1'b1));
    q.push_back(mk(1'b1, 5'd2, 32'h2, 1'b1));
    send(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    tick(3);

    // Idle port after everything drains
    chk_idle("final");
    chk("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
